mac_controller: RTL and testbench
=================================

MAC_CONTROLLER -- requirements
Module: mac_controller

Interface
REQ-001 SHALL have parameter N_INPUTS, default 16, meaning the number of input/weight pairs per neuron (legal range 1..256).
REQ-002 SHALL have parameter N_NEURONS, default 8, meaning the number of neurons per layer pass (legal range 1..256).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to run one layer pass; sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a pass.
REQ-008 SHALL have port in_addr, output, 8 bits: input-memory read address.
REQ-009 SHALL have port w_addr, output, 16 bits: weight-memory read address, equal to neuron*N_INPUTS+i.
REQ-010 SHALL have port b_addr, output, 8 bits: bias-memory read address, equal to the current neuron index.
REQ-011 SHALL have port rst_Acc, output, 1 bit: synchronous clear for the MAC accumulator.
REQ-012 SHALL have port ld_Acc, output, 1 bit: accumulator load enable for the MAC.
REQ-013 SHALL have port mac_result, input, 8 bits: the MAC post-bias ReLU output.
REQ-014 SHALL have port out_we, output, 1 bit: result-memory write strobe.
REQ-015 SHALL have port out_addr, output, 8 bits: result-memory write address, equal to the neuron index.
REQ-016 SHALL have port out_data, output, 8 bits: registered copy of mac_result.

Function
REQ-017 SHALL implement an FSM with states IDLE, CLEAR, ACCUM, DRAIN, WRITE and DONE.
REQ-018 SHALL, in IDLE with start=1, enter CLEAR with neuron=0 and i=0; start=0 keeps the FSM in IDLE.
REQ-019 SHALL, in CLEAR, assert rst_Acc for exactly one cycle and then enter ACCUM.
REQ-020 SHALL, in ACCUM, present address i each cycle, incrementing i from 0 to N_INPUTS-1, and enter DRAIN after address N_INPUTS-1.
REQ-021 SHALL treat memory as synchronous with 1-cycle read latency, so ld_Acc is address-issue delayed one cycle.
REQ-022 SHALL assert ld_Acc during the cycles ACCUM(1..N-1) plus DRAIN, giving exactly N_INPUTS ld_Acc pulses per neuron.
REQ-023 SHALL, in WRITE, assert out_we for one cycle with out_data=mac_result registered at DRAIN exit and out_addr=neuron.
REQ-024 SHALL, after WRITE, return to CLEAR with neuron+1 if neuron<N_NEURONS-1, else enter DONE.
REQ-025 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-026 SHALL make the per-neuron cost exactly N_INPUTS+3 cycles, and the start-to-done latency N_NEURONS*(N_INPUTS+3)+1 cycles.
REQ-027 SHALL ignore start while busy, with no queueing.
REQ-028 SHALL never assert rst_Acc and ld_Acc in the same cycle.
REQ-029 SHALL hold b_addr constant across CLEAR..WRITE of a neuron.
REQ-030 SHALL compute w_addr with 16-bit unsigned arithmetic, wrap-free for legal parameters.
REQ-031 SHALL handle the N_INPUTS=1 boundary with ACCUM lasting one cycle, then DRAIN with one ld_Acc.
REQ-032 SHALL handle the N_NEURONS=1 boundary with a single WRITE and then DONE.

Reset
REQ-033 SHALL, on rst=0, asynchronously force state=IDLE, neuron=0 and i=0.
REQ-034 SHALL, on rst=0, asynchronously force busy, done, rst_Acc, ld_Acc and out_we to 0, and out_data, in_addr, w_addr, b_addr and out_addr to 0.
REQ-035 SHALL, when reset occurs mid-pass, abandon the pass with no further out_we, and the next start SHALL begin at neuron 0.

Configuration
REQ-036 SHALL, with macro MAC_CTRL_ABORT_EN defined, add an input port abort (1 bit); abort=1 in any busy state SHALL go to IDLE next cycle, with no done, out_we or ld_Acc in that cycle.
REQ-037 SHALL, without MAC_CTRL_ABORT_EN, omit the abort port and its logic, and behave as REQ-017..REQ-032.

Verification
REQ-038 SHALL cover: N_INPUTS=4, N_NEURONS=2, single start pulse -> done at cycle 15, out_we at addr 0 then 1, and 8 ld_Acc pulses in total.
REQ-039 SHALL cover: all inputs 0x01, weights 0x02 and bias 0 with a MAC model -> out_data is consistent with the model, and w_addr sequence 0..3 then 4..7.
REQ-040 SHALL cover: start held high for 40 cycles -> exactly one pass per IDLE visit, with a second pass starting the cycle after done.
REQ-041 SHALL cover: rst=0 asserted in the ACCUM of neuron 1 -> outputs are 0 immediately, with no out_we for neuron 1.
REQ-042 SHALL cover: N_INPUTS=1, N_NEURONS=1 -> rst_Acc, ACCUM, DRAIN with ld_Acc=1, WRITE, then done at cycle 5.
REQ-043 SHALL cover: with MAC_CTRL_ABORT_EN, abort in WRITE-1 -> IDLE with no out_we and no done.

Source files
------------

// File: rtl/mac_controller.sv
// Layer-pass sequencer for a single MAC unit: walks neurons and inputs, issues memory addresses and
// accumulator controls, and writes one result per neuron. Optional abort input: define MAC_CTRL_ABORT_EN.
module mac_controller #(
   parameter int N_INPUTS  = 16,
   parameter int N_NEURONS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
`ifdef MAC_CTRL_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic [7:0]  in_addr,
   output logic [15:0] w_addr,
   output logic [7:0]  b_addr,
   output logic        rst_Acc,
   output logic        ld_Acc,
   input  logic [7:0]  mac_result,
   output logic        out_we,
   output logic [7:0]  out_addr,
   output logic [7:0]  out_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ACCUM = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [7:0]  LAST_I = 8'(N_INPUTS - 1);
   localparam logic [7:0]  LAST_N = 8'(N_NEURONS - 1);
   localparam logic [15:0] N_IN16 = 16'(N_INPUTS);

   logic [2:0] state;
   logic [7:0] neuron;
   logic [7:0] idx;
   logic       abort_hit;

`ifdef MAC_CTRL_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         neuron   <= '0;
         idx      <= '0;
         out_data <= '0;
      end else if (abort_hit) begin
         state  <= S_IDLE;
         neuron <= '0;
         idx    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_CLEAR;
                  neuron <= '0;
                  idx    <= '0;
               end
            end
            S_CLEAR: state <= S_ACCUM;
            S_ACCUM: begin
               if (idx == LAST_I) begin
                  state <= S_DRAIN;
                  idx   <= '0;
               end else begin
                  idx <= idx + 8'd1;
               end
            end
            // The last product lands this cycle; mac_result already includes it.
            S_DRAIN: begin
               out_data <= mac_result;
               state    <= S_WRITE;
            end
            S_WRITE: begin
               if (neuron == LAST_N) begin
                  state <= S_DONE;
               end else begin
                  neuron <= neuron + 8'd1;
                  state  <= S_CLEAR;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               neuron <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read data trails the address by one cycle, so loads skip ACCUM's first cycle and spill into DRAIN.
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE) && !abort_hit;
   assign rst_Acc  = (state == S_CLEAR);
   assign ld_Acc   = (((state == S_ACCUM) && (idx != 8'd0)) || (state == S_DRAIN)) && !abort_hit;
   assign out_we   = (state == S_WRITE) && !abort_hit;
   assign in_addr  = idx;
   assign b_addr   = neuron;
   assign out_addr = neuron;
   assign w_addr   = ({8'd0, neuron} * N_IN16) + {8'd0, idx};

endmodule

// File: tb/tb_mac_controller.sv
// Directed bench for mac_controller: a 4x2 instance fed by a small MAC/memory model and a 1x1 instance.
module tb_mac_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // 4-input, 2-neuron instance
   logic        start_a = 1'b0, abort_a = 1'b0;
   logic        busy_a, done_a, rst_acc_a, ld_acc_a, we_a;
   logic [7:0]  in_addr_a, b_addr_a, out_addr_a, out_data_a, mac_a;
   logic [15:0] w_addr_a;

   mac_controller #(.N_INPUTS(4), .N_NEURONS(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
`ifdef MAC_CTRL_ABORT_EN
      .abort(abort_a),
`endif
      .busy(busy_a), .done(done_a), .in_addr(in_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a),
      .rst_Acc(rst_acc_a), .ld_Acc(ld_acc_a), .mac_result(mac_a), .out_we(we_a),
      .out_addr(out_addr_a), .out_data(out_data_a)
   );

   // 1-input, 1-neuron instance
   logic        start_b = 1'b0, abort_b = 1'b0;
   logic        busy_b, done_b, rst_acc_b, ld_acc_b, we_b;
   logic [7:0]  in_addr_b, b_addr_b, out_addr_b, out_data_b;
   logic [7:0]  mac_b = 8'h5A;
   logic [15:0] w_addr_b;

   mac_controller #(.N_INPUTS(1), .N_NEURONS(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
`ifdef MAC_CTRL_ABORT_EN
      .abort(abort_b),
`endif
      .busy(busy_b), .done(done_b), .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
      .rst_Acc(rst_acc_b), .ld_Acc(ld_acc_b), .mac_result(mac_b), .out_we(we_b),
      .out_addr(out_addr_b), .out_data(out_data_b)
   );

   // Synchronous memories plus accumulator model; mac_a includes the product being loaded this cycle.
   logic [7:0]  in_mem [16];
   logic [7:0]  w_mem  [16];
   logic [7:0]  b_mem  [16];
   logic [7:0]  in_q = 8'd0, w_q = 8'd0;
   logic [15:0] acc = 16'd0;
   logic [15:0] sum;

   initial begin
      for (int j = 0; j < 16; j++) begin
         in_mem[j] = 8'h01;
         w_mem[j]  = 8'h02;
         b_mem[j]  = 8'h00;
      end
   end

   always @(posedge clk) begin
      in_q <= in_mem[in_addr_a[3:0]];
      w_q  <= w_mem[w_addr_a[3:0]];
      if (rst_acc_a)     acc <= 16'd0;
      else if (ld_acc_a) acc <= acc + 16'(in_q * w_q);
   end

   always_comb begin
      sum   = acc + (ld_acc_a ? 16'(in_q * w_q) : 16'd0) + {8'd0, b_mem[b_addr_a[3:0]]};
      mac_a = (sum > 16'd255) ? 8'hFF : sum[7:0];
   end

   int cnt_ld = 0, cnt_we = 0, cnt_ovl = 0, cnt_done = 0;
   always @(negedge clk) begin
      if (ld_acc_a) cnt_ld++;
      if (we_a) cnt_we++;
      if (done_a) cnt_done++;
      if (ld_acc_a && rst_acc_a) cnt_ovl++;
   end

   task automatic kick_a();
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      for (int t = 0; t < 100 && busy_a; t++) @(negedge clk);
      chk("idle_timeout", 32'(busy_a), 32'd0);
   endtask

   int d1, d2, b_ld, b_we, b_done;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_ctl", {rst_acc_a, ld_acc_a, we_a}, 32'd0);
      chk("rst_addr", {in_addr_a, b_addr_a, out_addr_a, out_data_a}, 32'd0);
      chk("rst_waddr", 32'(w_addr_a), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_hold", 32'(busy_a), 32'd0);

      // single pass, 4 inputs x 2 neurons
      b_ld = cnt_ld; b_we = cnt_we; d1 = 0;
      kick_a();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (done_a && d1 == 0) d1 = k;
         if (k == 1) chk("clr_pulse", 32'(rst_acc_a), 32'd1);
         if (k == 2) chk("first_ld", 32'(ld_acc_a), 32'd0);
         if (k >= 2 && k <= 5) chk("w_addr_n0", 32'(w_addr_a), 32'(k - 2));
         if (k >= 9 && k <= 12) chk("w_addr_n1", 32'(w_addr_a), 32'(k - 5));
         if (k == 8) chk("b_addr_n1", 32'(b_addr_a), 32'd1);
         if (k == 7) chk("wr0", {we_a, out_addr_a, out_data_a}, {15'd0, 1'b1, 8'd0, 8'd8});
         if (k == 14) chk("wr1", {we_a, out_addr_a, out_data_a}, {15'd0, 1'b1, 8'd1, 8'd8});
      end
      chk("done_cycle", 32'(d1), 32'd15);
      chk("ld_count", 32'(cnt_ld - b_ld), 32'd8);
      chk("we_count", 32'(cnt_we - b_we), 32'd2);
      chk("ld_rst_overlap", 32'(cnt_ovl), 32'd0);

      // start held high: one pass per IDLE visit
      d1 = 0; d2 = 0; b_done = cnt_done;
      @(negedge clk);
      start_a = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done_a) begin
            if (d1 == 0) d1 = k;
            else if (d2 == 0) d2 = k;
         end
         if (k == 16) chk("idle_after_done", 32'(busy_a), 32'd0);
         if (k == 17) chk("restart_clear", 32'(rst_acc_a), 32'd1);
      end
      start_a = 1'b0;
      chk("held_done1", 32'(d1), 32'd15);
      chk("held_done2", 32'(d2), 32'd31);
      chk("held_done_cnt", 32'(cnt_done - b_done), 32'd2);
      wait_idle_a();

      // reset during ACCUM of neuron 1
      b_we = cnt_we;
      kick_a();
      repeat (10) @(negedge clk);
      chk("pre_rst_neuron", 32'(b_addr_a), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_ctl", {done_a, rst_acc_a, ld_acc_a, we_a}, 32'd0);
      chk("mid_rst_addr", {in_addr_a, b_addr_a, out_addr_a, out_data_a}, 32'd0);
      chk("mid_rst_waddr", 32'(w_addr_a), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("no_we_after_rst", 32'(cnt_we - b_we), 32'd1);
      kick_a();
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) chk("restart_n0", {rst_acc_a, b_addr_a}, {23'd0, 1'b1, 8'd0});
         if (k == 7) chk("restart_wr0", {we_a, out_addr_a}, {23'd0, 1'b1, 8'd0});
      end
      wait_idle_a();

      // 1 input x 1 neuron boundary
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) chk("b_clear", {busy_b, rst_acc_b, ld_acc_b}, 32'b110);
         if (k == 2) chk("b_accum", {busy_b, rst_acc_b, ld_acc_b, we_b}, 32'b1000);
         if (k == 3) chk("b_drain", {ld_acc_b, we_b}, 32'b10);
         if (k == 4) chk("b_write", {we_b, out_addr_b, out_data_b}, {15'd0, 1'b1, 8'd0, 8'h5A});
         if (k == 5) chk("b_done", {done_b, we_b}, 32'b10);
         if (k == 6) chk("b_idle", {busy_b, done_b}, 32'b00);
      end

`ifdef MAC_CTRL_ABORT_EN
      // abort in the cycle before neuron 1's WRITE
      b_we = cnt_we; b_done = cnt_done;
      kick_a();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 13) begin
            abort_a = 1'b1;
            #1 chk("abort_ld_gate", 32'(ld_acc_a), 32'd0);
         end
         if (k == 14) begin
            abort_a = 1'b0;
            chk("abort_idle", {busy_a, we_a}, 32'd0);
         end
      end
      chk("abort_we_cnt", 32'(cnt_we - b_we), 32'd1);
      chk("abort_no_done", 32'(cnt_done - b_done), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
